// File: rtl/generic_spi_peripheral_emu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : generic_spi_pkg                                       |
// | Brief    : Shared types and constants for the SPI peripheral emu |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package generic_spi_pkg;

  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    FRAME_END = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/generic_spi_peripheral_emu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : generic_spi_peripheral_emu_if                         |
// | Brief    : Register-side bundle of the SPI peripheral emulator   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface generic_spi_peripheral_emu_if;
  import generic_spi_pkg::*;

  logic                 enable;
  logic [WORD_BITS-1:0] tx_mem_write;
  logic                 tx_mem_write_strb;
  logic [31:0]          tx_mem_write_ptr;
  logic                 tx_mem_write_ptr_reset;
  logic [WORD_BITS-1:0] rx_mem_read;
  logic                 rx_mem_read_strb;
  logic [31:0]          rx_mem_read_ptr;
  logic                 rx_mem_read_ptr_reset;
  logic                 clear_status;
  logic [31:0]          frame_count;
  logic [31:0]          last_frame_bits;
  logic [2:0]           status;

  modport master (
    output enable, tx_mem_write, tx_mem_write_strb, tx_mem_write_ptr_reset,
           rx_mem_read_strb, rx_mem_read_ptr_reset, clear_status,
    input  tx_mem_write_ptr, rx_mem_read, rx_mem_read_ptr, frame_count,
           last_frame_bits, status
  );

  modport slave (
    input  enable, tx_mem_write, tx_mem_write_strb, tx_mem_write_ptr_reset,
           rx_mem_read_strb, rx_mem_read_ptr_reset, clear_status,
    output tx_mem_write_ptr, rx_mem_read, rx_mem_read_ptr, frame_count,
           last_frame_bits, status
  );

endinterface
`default_nettype wire

// File: rtl/generic_spi_peripheral_emu_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : spi_input_sync                                        |
// | Brief    : N-flop synchronizer with previous-value edge detect   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  wire logic axi_clk,
  input  wire logic axi_resetn,
  input  wire logic d,
  output logic      q,
  output logic      rise,
  output logic      fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Reset to the line's idle level so releasing reset creates no edge
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise =  r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/generic_spi_peripheral_emu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : generic_spi_peripheral_emu                            |
// | Brief    : Oversampled SPI responder with TX/RX word memories    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module generic_spi_peripheral_emu
  import generic_spi_pkg::*;
#(
  parameter int MEM_DEPTH   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic axi_clk,
  input  wire logic axi_resetn,
  input  wire logic spi_clk,
  input  wire logic cs_b,
  input  wire logic pico,
  output logic      poci,
  generic_spi_peripheral_emu_if.slave regs
);

  localparam int          c_PTR_W    = $clog2(MEM_DEPTH);
  localparam logic [31:0] c_MAX_BITS = 32'(MEM_DEPTH * WORD_BITS);

  logic w_s_clk, w_clk_rise, w_clk_fall;
  logic w_s_cs_b, w_cs_rise, w_cs_fall;
  logic w_s_pico, w_pico_rise, w_pico_fall;
  logic w_unused_sync;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .d(spi_clk),
    .q(w_s_clk), .rise(w_clk_rise), .fall(w_clk_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .d(cs_b),
    .q(w_s_cs_b), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pico (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .d(pico),
    .q(w_s_pico), .rise(w_pico_rise), .fall(w_pico_fall)
  );

  assign w_unused_sync = &{1'b0, w_s_clk, w_s_cs_b, w_pico_rise, w_pico_fall};

  state_t               r_state, w_next_state;
  logic [31:0]          r_bit_cnt;
  logic                 r_overflow;
  logic [31:0]          r_frame_count;
  logic [31:0]          r_last_bits;
  logic                 r_tx_strb_d;
  logic [c_PTR_W-1:0]   r_tx_ptr;
  logic [c_PTR_W-1:0]   r_rx_ptr;
  logic [WORD_BITS-1:0] r_tx_mem [MEM_DEPTH];
  logic [WORD_BITS-1:0] r_rx_mem [MEM_DEPTH];

  logic [c_PTR_W-1:0] w_word_idx;
  logic [4:0]         w_bit_idx;
  logic               w_ovf;
  logic               w_rx_we;

  assign w_word_idx = r_bit_cnt[c_PTR_W+4:5];
  assign w_bit_idx  = r_bit_cnt[4:0];
  assign w_ovf      = (r_bit_cnt >= c_MAX_BITS);

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= IDLE;
    else             r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_rx_we      = 1'b0;
    case (r_state)
      IDLE:      if (regs.enable && w_cs_fall) w_next_state = ACTIVE;
      ACTIVE: begin
        w_rx_we = w_clk_rise && !w_ovf;
        if (w_cs_rise) w_next_state = FRAME_END;
      end
      FRAME_END: w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      poci          <= 1'b0;
      r_bit_cnt     <= '0;
      r_overflow    <= 1'b0;
      r_frame_count <= '0;
      r_last_bits   <= '0;
    end else begin
      case (r_state)
        // Keep bit 0 presented so it is valid before the first rising edge
        IDLE: poci <= r_tx_mem[0][0];
        ACTIVE: begin
          if (w_clk_rise) begin
            r_bit_cnt <= r_bit_cnt + 32'd1;
            if (w_ovf) r_overflow <= 1'b1;
          end
          if (w_clk_fall) poci <= w_ovf ? 1'b0 : r_tx_mem[w_word_idx][w_bit_idx];
        end
        FRAME_END: begin
          r_frame_count <= r_frame_count + 32'd1;
          r_last_bits   <= r_bit_cnt;
          r_bit_cnt     <= '0;
        end
        default: ;
      endcase
      if (regs.clear_status) begin
        r_overflow    <= 1'b0;
        r_frame_count <= '0;
        r_last_bits   <= '0;
      end
    end
  end

  // Pointer resets take priority over the advancing strobes
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_tx_strb_d <= 1'b0;
      r_tx_ptr    <= '0;
      r_rx_ptr    <= '0;
    end else begin
      r_tx_strb_d <= regs.tx_mem_write_strb;
      if (regs.tx_mem_write_ptr_reset) r_tx_ptr <= '0;
      else if (r_tx_strb_d)            r_tx_ptr <= r_tx_ptr + 1'b1;
      if (regs.rx_mem_read_ptr_reset)  r_rx_ptr <= '0;
      else if (regs.rx_mem_read_strb)  r_rx_ptr <= r_rx_ptr + 1'b1;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (r_tx_strb_d) r_tx_mem[r_tx_ptr] <= regs.tx_mem_write;
    if (w_rx_we)     r_rx_mem[w_word_idx][w_bit_idx] <= w_s_pico;
  end

  assign regs.rx_mem_read      = r_rx_mem[r_rx_ptr];
  assign regs.rx_mem_read_ptr  = 32'(r_rx_ptr);
  assign regs.tx_mem_write_ptr = 32'(r_tx_ptr);
  assign regs.frame_count      = r_frame_count;
  assign regs.last_frame_bits  = r_last_bits;
  assign regs.status           = {r_overflow, r_state};

endmodule
`default_nettype wire

// File: doc/generic_spi_peripheral_emu.md
# generic_spi_peripheral_emu

FPGA-side emulation of the generic SPI peripheral ASIC block, i.e. the responder end of the generic SPI controller's bus. It oversamples spi_clk/cs_b/pico in the axi_clk domain, stores received pico bits LSB-first into an RX word memory, and shifts poci out of a TX word memory. It gives a register-accessible loopback target for controller bring-up and for firmware tests without an ASIC.

## Interface
- MEM_DEPTH, 64, words in each of TX and RX memory; power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops per SPI input; at least 2.

- axi_clk  in  1  system clock.
- axi_resetn  in  1  reset: asynchronous, active-low.
- spi_clk  in  1  SPI clock from the controller (asynchronous to axi_clk).
- cs_b  in  1  chip select, active-low.
- pico  in  1  controller-to-peripheral data.
- poci  out  1  peripheral-to-controller data. Reset value 0.
- enable  in  1  accept frames when high. Sampled only in IDLE.
- tx_mem_write  in  32  word to load into TX memory.
- tx_mem_write_strb  in  1  load strobe. The write uses tx_mem_write from the following cycle.
- tx_mem_write_ptr  out  32  next TX word to be written, zero-extended. Reset value 0.
- tx_mem_write_ptr_reset  in  1  clear tx_mem_write_ptr.
- rx_mem_read  out  32  RX memory word at rx_mem_read_ptr. Combinational.
- rx_mem_read_strb  in  1  advance rx_mem_read_ptr.
- rx_mem_read_ptr  out  32  zero-extended. Reset value 0.
- rx_mem_read_ptr_reset  in  1  clear rx_mem_read_ptr.
- clear_status  in  1  clear overflow, frame_count and last_frame_bits.
- frame_count  out  32  completed frames. Reset value 0.
- last_frame_bits  out  32  rising spi_clk edges seen in the last completed frame. Reset value 0.
- status  out  3  {overflow, state[1:0]}. Reset value 0.

## Operation
- spi_clk, cs_b and pico each pass through SYNC_STAGES flops, plus one more flop for edge detection. The synchronized values are called s_clk, s_cs_b and s_pico.
- States are IDLE=0, ACTIVE=1, FRAME_END=2.
  - IDLE -> ACTIVE when enable=1 and s_cs_b falls. bit_cnt is 0 at entry.
  - ACTIVE -> FRAME_END when s_cs_b rises.
  - FRAME_END -> IDLE unconditionally, after one cycle.
- In ACTIVE, on each s_clk rising edge:
  - Write s_pico into rx_mem[bit_cnt[.. :5]][bit_cnt[4:0]].
  - Increment bit_cnt (32 bits).
- In ACTIVE, on each s_clk falling edge: poci <= tx_mem[bit_cnt/32][bit_cnt%32].
- In IDLE, poci <= tx_mem[0][0] every cycle, so bit 0 is valid before the first rising edge.
- In FRAME_END:
  - frame_count increments.
  - last_frame_bits <= bit_cnt.
  - bit_cnt <= 0.
  - A frame with zero clock edges still counts.
- Overflow: when bit_cnt reaches MEM_DEPTH*32 or more, the RX write is suppressed and poci is driven 0. The sticky overflow bit is set on the first suppressed edge.
- Pointers are $clog2(MEM_DEPTH) bits wide and wrap modulo MEM_DEPTH.
  - Delayed write strobe and tx_mem_write_ptr_reset in the same cycle: the word is written at the old pointer, then the pointer becomes 0.
  - rx_mem_read_strb and rx_mem_read_ptr_reset in the same cycle: the pointer becomes 0.
- clear_status in the same cycle as FRAME_END: clear wins, and the counters become 0.
- TX writes during ACTIVE are allowed. Which word value is shifted out for bits already addressed is unspecified.
- enable falling mid-frame does not abort the frame.

## Timing
- Capture latency: SYNC_STAGES+1 axi_clk cycles from a real spi_clk edge to the RX write or poci update.
- Required spi_clk profile: each high phase and each low phase lasts at least SYNC_STAGES+3 axi_clk periods. This guarantees poci settles before the controller's next rising-edge sample.
- A cs_b fall to the first spi_clk rise of at least one spi_clk half-period is supported.
- Reset mid-frame: asynchronous return to IDLE and all outputs take their reset values. Memory contents are not cleared. Edges already in the synchronizer are discarded.
- status reflects the registered state with no added delay.

## Structure
- The shared package generic_spi_pkg holds:
  - the peripheral state enum (IDLE/ACTIVE/FRAME_END);
  - WORD_BITS=32.
- One sub-module, spi_input_sync: an N-stage synchronizer plus previous-value flop, with outputs q, rise and fall. It is instantiated three times.
- The memories are plain register arrays.

## Test plan
- Load TX words 0xA5A5_0F0F and 0x1234_5678, then run a 64-bit frame with pico words 0xDEAD_BEEF and 0x0BAD_F00D. Required:
  - RX words 0 and 1 equal 0xDEAD_BEEF and 0x0BAD_F00D;
  - the controller reads back 0xA5A5_0F0F and 0x1234_5678;
  - frame_count=1 and last_frame_bits=64.
- Run a 5-bit frame, then a 0-bit frame (cs_b pulse only). Required: frame_count=2, last_frame_bits=0, and RX word 0 low 5 bits equal the sent bits.
- With MEM_DEPTH=2, send a 70-bit frame. Required:
  - overflow=1;
  - bits 64-69 are not stored and poci=0 during them;
  - RX words 0 and 1 are intact.
- Pulse tx_mem_write_strb 65 times with MEM_DEPTH=64. Required: the pointer wraps to 1 and word 0 holds the 65th value. Also assert the delayed strobe and the pointer reset together and check the write goes to the old pointer and the pointer becomes 0.
- Assert axi_resetn low at bit 17 of a frame. Required: state=IDLE, poci=0, counters=0. A following full frame then completes normally.
- Hold enable=0 during a frame: no RX writes and frame_count unchanged. Then drop enable mid-frame: the frame still completes and is counted.
